network_mac_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate unit; next generation of the network's fixed 16x16 combinational multiplier.
- Takes a stream of operand pairs framed by first/last markers and accumulates their products, one product per cycle.
- At the end of each frame it emits one rounded, saturated fixed-point result.
- Uses valid/ready handshakes on both sides, so it drops into the convolution datapath between the line buffers and the activation stage.

---
 rtl/network_mac_pipe.sv | 105 ++++++++++
 tb/tb_network_mac_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/network_mac_pipe.sv
// network_mac_pipe: pipelined multiply-accumulate over first/last framed operand streams,
// emitting one rounded, saturated fixed-point result per frame with valid/ready on both sides.
module network_mac_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int SIGNED    = 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int XW = ACC_WIDTH - PW;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic [RW-1:0] HALF = FRAC_BITS > 0 ? RW'(1) << (FRAC_BITS > 0 ? FRAC_BITS - 1 : 0) : '0;
  localparam logic signed [RW-1:0] SMAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [RW-1:0] UMAX = {{(RW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic                 en;
  logic [A_WIDTH-1:0]   a1;
  logic [B_WIDTH-1:0]   b1;
  logic                 f1, l1, v1;
  logic [PW-1:0]        p2;
  logic                 f2, l2, v2;
  logic [ACC_WIDTH-1:0] acc;
  logic                 l3, v3;
  logic signed [PW-1:0] prod_s;
  logic [PW-1:0]        prod_u;
  logic [ACC_WIDTH-1:0] ext;
  logic [RW-1:0]        acc_x, rnd, sh_u;
  logic signed [RW-1:0] sh_s;
  logic                 hi, lo;
  logic [OUT_WIDTH-1:0] sat_val, res;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  assign prod_s = PW'($signed(a1)) * PW'($signed(b1));
  assign prod_u = PW'(a1) * PW'(b1);
  assign ext    = {{XW{SIGNED != 0 ? p2[PW-1] : 1'b0}}, p2};

  // One guard bit above the accumulator keeps the rounding add from overflowing.
  assign acc_x   = {SIGNED != 0 ? acc[ACC_WIDTH-1] : 1'b0, acc};
  assign rnd     = acc_x + HALF;
  assign sh_s    = $signed(rnd) >>> FRAC_BITS;
  assign sh_u    = rnd >> FRAC_BITS;
  assign hi      = SIGNED != 0 ? sh_s > SMAX : sh_u > UMAX;
  assign lo      = SIGNED != 0 && sh_s < SMIN;
  assign sat_val = SIGNED != 0 ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : {OUT_WIDTH{1'b1}};
  assign res     = hi ? sat_val : lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                   SIGNED != 0 ? sh_s[OUT_WIDTH-1:0] : sh_u[OUT_WIDTH-1:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a1        <= '0;
      b1        <= '0;
      f1        <= 1'b0;
      l1        <= 1'b0;
      v1        <= 1'b0;
      p2        <= '0;
      f2        <= 1'b0;
      l2        <= 1'b0;
      v2        <= 1'b0;
      acc       <= '0;
      l3        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      a1 <= in_a;
      b1 <= in_b;
      f1 <= in_first;
      l1 <= in_last;
      v1 <= in_valid;
      p2 <= SIGNED != 0 ? prod_s : prod_u;
      f2 <= f1;
      l2 <= l1;
      v2 <= v1;
      if (v2) acc <= (f2 ? '0 : acc) + ext;
      l3 <= l2;
      v3 <= v2;
      if (v3 && l3) begin
        out_data  <= res;
        out_sat   <= hi | lo;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_network_mac_pipe.sv
// tb_network_mac_pipe: directed vector table, multi-cycle corner sequences and a randomized
// stream checked against a frame-level arithmetic reference model.
module tb_network_mac_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_first, in_last;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_sat;
  logic [15:0] out_data;
  logic        u_in_ready, u_out_valid, u_out_sat;
  logic [15:0] u_out_data;

  always #5 clk = ~clk;

  network_mac_pipe dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  network_mac_pipe #(.SIGNED(0)) u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(u_out_valid), .out_ready(1'b1), .out_data(u_out_data), .out_sat(u_out_sat)
  );

  typedef struct {
    logic [15:0] a, b, sd;
    logic        ss;
    logic [15:0] ud;
    logic        us;
  } vec_t;

  int          checks = 0;
  int          passed = 0;
  longint      macc = 0;
  logic [16:0] expq[$];
  vec_t        tbl[10];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Frame result in Q8.8 from a 40-bit signed accumulator: round half up, then clamp.
  function automatic logic [16:0] ref_result(input longint acc);
    longint r;
    logic   sat;
    sat = 1'b0;
    r = (acc + 128) >>> 8;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return {sat, r[15:0]};
  endfunction

  task automatic observe();
    logic [16:0] e;
    if (rst_n) begin
      chk("in_ready_rule", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (in_valid && in_ready) begin
        if (in_first) macc = 0;
        macc = macc + longint'($signed(in_a)) * longint'($signed(in_b));
        macc = (macc <<< 24) >>> 24;
        if (in_last) expq.push_back(ref_result(macc));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = expq.pop_front();
          chk("model_data", out_data, e[15:0]);
          chk("model_sat", out_sat, e[16]);
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic f, input logic l);
    in_valid = v; in_a = a; in_b = b; in_first = f; in_last = l;
  endtask

  task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic f,
                            output int k);
    set_in(1'b1, a, b, f, 1'b1);
    cyc();
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    k = 1;
    while (!out_valid && k < 20) begin
      cyc();
      k++;
    end
  endtask

  initial begin
    int          k, n, fj, lj;
    logic        found, prev_rdy;
    logic [15:0] got[4];
    logic [11:0] s;
    tbl[0] = '{16'h0100, 16'h0200, 16'h0200, 1'b0, 16'h0200, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[2] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h0001, 16'h0080, 16'h0001, 1'b0, 16'h0001, 1'b0};
    tbl[4] = '{16'h0001, 16'h007F, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'h8000, 1'b0};
    tbl[6] = '{16'hFF00, 16'h0100, 16'hFF00, 1'b0, 16'hFF00, 1'b0};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b1};
    tbl[8] = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[9] = '{16'hFFFF, 16'h0180, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1};

    rst_n = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_sat", out_sat, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) begin
      run_single(tbl[i].a, tbl[i].b, 1'b1, k);
      chk($sformatf("latency_%0d", i), k, 4);
      chk($sformatf("s_data_%0d", i), out_data, tbl[i].sd);
      chk($sformatf("s_sat_%0d", i), out_sat, tbl[i].ss);
      chk($sformatf("u_valid_%0d", i), u_out_valid, 1);
      chk($sformatf("u_data_%0d", i), u_out_data, tbl[i].ud);
      chk($sformatf("u_sat_%0d", i), u_out_sat, tbl[i].us);
    end

    set_in(1'b1, 16'h0100, 16'h0100, 1'b1, 1'b0); cyc();
    set_in(1'b1, 16'hFF00, 16'h0300, 1'b0, 1'b0); cyc();
    set_in(1'b1, 16'h0080, 16'h0100, 1'b0, 1'b1); cyc();
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n = 0;
    got[0] = '0;
    for (int j = 0; j < 10; j++) begin
      if (out_valid) begin n++; got[0] = out_data; end
      cyc();
    end
    chk("frame_count", n, 1);
    chk("frame_data", got[0], 16'hFE80);

    n = 0; fj = 0; lj = 0;
    for (int j = 0; j < 12; j++) begin
      if (j < 4) set_in(1'b1, 16'h0100, 16'((j + 1) * 256), 1'b1, 1'b1);
      else set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      cyc();
      if (out_valid) begin
        if (n == 0) fj = j;
        lj = j;
        if (n < 4) got[n] = out_data;
        n++;
      end
    end
    chk("b2b_count", n, 4);
    chk("b2b_span", lj - fj, 3);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_data_%0d", i), got[i], (i + 1) * 256);

    out_ready = 1'b0;
    prev_rdy = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 12 && !found; j++) begin
      set_in(1'b1, 16'h0100, 16'h0100, 1'b1, 1'b1);
      cyc();
      if (out_valid) begin
        found = 1'b1;
        chk("stall_ready_low", in_ready, 0);
        chk("ready_before_stall", prev_rdy, 1);
      end
      prev_rdy = in_ready;
    end
    chk("stall_seen", found, 1);
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 16'h0100);
      chk("hold_ready", in_ready, 0);
    end

    for (int j = 0; j < 800; j++) begin
      s = 12'($urandom);
      in_valid = $urandom_range(3) != 0;
      in_a = $urandom_range(1) == 1 ? 16'($urandom) : {{4{s[11]}}, s};
      s = 12'($urandom);
      in_b = $urandom_range(2) == 0 ? 16'($urandom) : {{4{s[11]}}, s};
      in_first = $urandom_range(3) == 0;
      in_last = $urandom_range(3) == 0;
      out_ready = $urandom_range(9) < 7;
      cyc();
    end
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int j = 0; j < 12; j++) cyc();
    chk("drain_queue_empty", expq.size(), 0);

    out_ready = 1'b0;
    set_in(1'b1, 16'h0100, 16'h0100, 1'b1, 1'b1); cyc();
    set_in(1'b1, 16'h0200, 16'h0200, 1'b1, 1'b0); cyc();
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      cyc();
      k++;
    end
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_data", out_data, 0);
    chk("async_reset_sat", out_sat, 0);
    chk("async_reset_ready", in_ready, 1);
    expq.delete();
    macc = 0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    run_single(16'h0100, 16'h0100, 1'b0, k);
    chk("post_reset_nofirst_lat", k, 4);
    chk("post_reset_nofirst_data", out_data, 16'h0100);
    run_single(16'h0100, 16'h0100, 1'b1, k);
    chk("post_reset_data", out_data, 16'h0100);
    chk("post_reset_sat", out_sat, 0);
    for (int j = 0; j < 6; j++) cyc();
    chk("final_queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
